// File: rtl/rsa_mont_exp.sv
// Modular exponentiation controller: sequences Montgomery multiplications
// (right-to-left square-and-multiply) over a single outstanding request.
module rsa_mont_exp #(
  parameter int unsigned MOD_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_msg,
  input  logic [MOD_WIDTH-1:0] i_key,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  input  logic [MOD_WIDTH-1:0] i_r2,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_result,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MOD_WIDTH-1:0] m_a,
  output logic [MOD_WIDTH-1:0] m_b,
  output logic [MOD_WIDTH-1:0] m_modulus,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [MOD_WIDTH-1:0] r_out
);

  localparam int unsigned          CNT_W    = (MOD_WIDTH > 1) ? $clog2(MOD_WIDTH) : 1;
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(MOD_WIDTH - 1);
  localparam logic [MOD_WIDTH-1:0] ONE      = MOD_WIDTH'(1);

  // Every Montgomery op is a SEND state (request pending) followed by a WAIT state.
  typedef enum logic [3:0] {
    IDLE,
    PRE_BASE_S, PRE_BASE_W,
    PRE_ACC_S,  PRE_ACC_W,
    MUL_S,      MUL_W,
    SQR_S,      SQR_W,
    POST_S,     POST_W,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [MOD_WIDTH-1:0] msg_q, msg_d;
  logic [MOD_WIDTH-1:0] key_q, key_d;
  logic [MOD_WIDTH-1:0] r2_q, r2_d;
  logic [MOD_WIDTH-1:0] base_q, base_d;
  logic [MOD_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MOD_WIDTH-1:0] o_result_d, m_a_d, m_b_d, m_modulus_d;
  logic                 i_ready_d, o_valid_d, m_valid_d, r_ready_d;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    key_d       = key_q;
    r2_d        = r2_q;
    base_d      = base_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    o_result_d  = o_result;
    m_a_d       = m_a;
    m_b_d       = m_b;
    m_modulus_d = m_modulus;
    i_ready_d   = 1'b0;
    o_valid_d   = 1'b0;
    m_valid_d   = 1'b0;
    r_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          msg_d       = i_msg;
          key_d       = i_key;
          r2_d        = i_r2;
          m_modulus_d = i_modulus;
          cnt_d       = '0;
          state_d     = PRE_BASE_S;
        end
      end
      PRE_BASE_S: if (m_ready) state_d = PRE_BASE_W;
      PRE_ACC_S:  if (m_ready) state_d = PRE_ACC_W;
      MUL_S:      if (m_ready) state_d = MUL_W;
      SQR_S:      if (m_ready) state_d = SQR_W;
      POST_S:     if (m_ready) state_d = POST_W;
      PRE_BASE_W: begin
        if (r_valid) begin
          base_d  = r_out;
          state_d = PRE_ACC_S;
        end
      end
      PRE_ACC_W: begin
        // Enter the loop at bit 0; a clear key bit skips straight past MUL.
        if (r_valid) begin
          acc_d   = r_out;
          state_d = key_q[cnt_q] ? MUL_S : ((cnt_q == LAST_BIT) ? POST_S : SQR_S);
        end
      end
      MUL_W: begin
        if (r_valid) begin
          acc_d   = r_out;
          state_d = (cnt_q == LAST_BIT) ? POST_S : SQR_S;
        end
      end
      SQR_W: begin
        // SQR is never reached on the last bit, so the counter cannot wrap.
        if (r_valid) begin
          base_d  = r_out;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = key_q[cnt_d] ? MUL_S : ((cnt_d == LAST_BIT) ? POST_S : SQR_S);
        end
      end
      POST_W: begin
        if (r_valid) begin
          o_result_d = r_out;
          state_d    = DONE;
        end
      end
      DONE: if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered, using the freshly updated operands.
    i_ready_d = (state_d == IDLE);
    o_valid_d = (state_d == DONE);
    case (state_d)
      PRE_BASE_S: begin m_valid_d = 1'b1; m_a_d = msg_d;  m_b_d = r2_d;   end
      PRE_ACC_S:  begin m_valid_d = 1'b1; m_a_d = ONE;    m_b_d = r2_q;   end
      MUL_S:      begin m_valid_d = 1'b1; m_a_d = acc_d;  m_b_d = base_d; end
      SQR_S:      begin m_valid_d = 1'b1; m_a_d = base_d; m_b_d = base_d; end
      POST_S:     begin m_valid_d = 1'b1; m_a_d = acc_d;  m_b_d = ONE;    end
      PRE_BASE_W, PRE_ACC_W, MUL_W, SQR_W, POST_W: r_ready_d = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      msg_q     <= '0;
      key_q     <= '0;
      r2_q      <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      o_result  <= '0;
      m_a       <= '0;
      m_b       <= '0;
      m_modulus <= '0;
      i_ready   <= 1'b1;
      o_valid   <= 1'b0;
      m_valid   <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      key_q     <= key_d;
      r2_q      <= r2_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      o_result  <= o_result_d;
      m_a       <= m_a_d;
      m_b       <= m_b_d;
      m_modulus <= m_modulus_d;
      i_ready   <= i_ready_d;
      o_valid   <= o_valid_d;
      m_valid   <= m_valid_d;
      r_ready   <= r_ready_d;
    end
  end

endmodule

// File: tb/tb_rsa_mont_exp.sv
// Bench for rsa_mont_exp at MOD_WIDTH=8 with a behavioural Montgomery responder.
`timescale 1ns/1ps
module tb_rsa_mont_exp;

  localparam int unsigned W       = 8;
  localparam int unsigned N       = 221;
  localparam int unsigned R2      = 120;
  localparam int          TIMEOUT = 5000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] i_msg = '0, i_key = '0, i_modulus = '0, i_r2 = '0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_result;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_a, m_b, m_modulus;
  logic         r_valid = 1'b0;
  logic         r_ready;
  logic [W-1:0] r_out = '0;

  int checks = 0;
  int errors = 0;
  int op_count = 0;
  bit stall = 1'b0;

  // Responder state.
  bit           busy = 1'b0, m_fire = 1'b0, r_fire = 1'b0, stall_prev = 1'b0;
  int           delay = 0;
  int unsigned  resp = 0;
  logic [W-1:0] prev_a = '0, prev_b = '0;

  typedef struct {
    int unsigned msg;
    int unsigned key;
    int unsigned res;
    int unsigned ops;
  } vec_t;
  vec_t vecs[5];

  rsa_mont_exp #(.MOD_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_msg(i_msg), .i_key(i_key), .i_modulus(i_modulus), .i_r2(i_r2),
    .o_valid(o_valid), .o_ready(o_ready), .o_result(o_result),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_a(m_a), .m_b(m_b), .m_modulus(m_modulus),
    .r_valid(r_valid), .r_ready(r_ready), .r_out(r_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // a*b*2^-W mod N, bit-serial.
  function automatic int unsigned mont(input int unsigned a, input int unsigned b);
    int unsigned t;
    t = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (a[i]) t += b;
      if (t[0]) t += N;
      t = t >> 1;
    end
    if (t >= N) t -= N;
    return t;
  endfunction

  // Montgomery multiplier model: one request at a time, optional random stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 0; m_fire = 0; r_fire = 0; stall_prev = 0;
        r_valid = 1'b0; m_ready = 1'b0;
      end else begin
        if (r_fire) begin r_valid = 1'b0; busy = 0; r_fire = 0; end
        if (m_fire) begin busy = 1; delay = stall ? int'($urandom_range(0, 3)) : 0; m_fire = 0; end
        if (stall_prev) begin
          check("m_valid_held", m_valid, 1);
          check("m_a_held", m_a, prev_a);
          check("m_b_held", m_b, prev_b);
        end
        if (m_valid || r_ready) check("m_valid_r_ready_exclusive", m_valid && r_ready, 0);
        if (busy && !r_valid) begin
          if (delay == 0) begin r_valid = 1'b1; r_out = W'(resp); end
          else delay--;
        end
        m_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_fire = m_valid && m_ready;
        if (m_fire) begin
          check("one_outstanding", busy, 0);
          check("m_modulus", m_modulus, N);
          resp = mont(m_a, m_b);
          op_count++;
        end
        stall_prev = m_valid && !m_ready;
        prev_a = m_a;
        prev_b = m_b;
        r_fire = r_valid && r_ready;
      end
    end
  end

  task automatic wait_ready(input string tag);
    int cyc;
    cyc = 0;
    while (!i_ready && cyc < TIMEOUT) begin @(negedge clk); cyc++; end
    if (!i_ready) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout actual=%0d required=1", tag, i_ready);
    end
  endtask

  // Waits for o_valid, checks result and op count, optionally holds o_ready low, then handshakes.
  task automatic finish_job(input string tag, input int unsigned exp_res,
                            input int unsigned exp_ops, input int hold);
    int cyc;
    logic ir_bad;
    logic [W-1:0] held;
    cyc = 0; ir_bad = 1'b0;
    while (!o_valid && cyc < TIMEOUT) begin
      if (i_ready) ir_bad = 1'b1;
      @(negedge clk); cyc++;
    end
    if (!o_valid) begin
      checks++; errors++;
      $display("FAIL %s_result_timeout actual=%0d required=1", tag, o_valid);
      return;
    end
    if (i_ready) ir_bad = 1'b1;
    check($sformatf("%s_i_ready_low", tag), ir_bad, 0);
    held = o_result;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check($sformatf("%s_o_valid_held", tag), o_valid, 1);
      check($sformatf("%s_o_result_held", tag), o_result, held);
      check($sformatf("%s_i_ready_held", tag), i_ready, 0);
    end
    check($sformatf("%s_result", tag), o_result, exp_res);
    check($sformatf("%s_ops", tag), op_count, exp_ops);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    check($sformatf("%s_o_valid_drop", tag), o_valid, 0);
    check($sformatf("%s_i_ready_back", tag), i_ready, 1);
  endtask

  task automatic run_job(input string tag, input int unsigned msg, input int unsigned key,
                         input int unsigned exp_res, input int unsigned exp_ops, input int hold);
    wait_ready(tag);
    op_count = 0;
    i_msg = W'(msg); i_key = W'(key); i_modulus = W'(N); i_r2 = W'(R2);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    finish_job(tag, exp_res, exp_ops, hold);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{msg: 5,   key: 3,  res: 125, ops: 12};
    vecs[1] = '{msg: 7,   key: 13, res: 176, ops: 13};
    vecs[2] = '{msg: 2,   key: 0,  res: 1,   ops: 10};
    vecs[3] = '{msg: 0,   key: 9,  res: 0,   ops: 12};
    vecs[4] = '{msg: 200, key: 1,  res: 200, ops: 11};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_i_ready", i_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_o_result", o_result, 0);
    check("rst_m_a", m_a, 0);
    check("rst_m_b", m_b, 0);
    check("rst_m_modulus", m_modulus, 0);
    rst = 1'b1;
    @(negedge clk);

    // Table, no stalls.
    stall = 1'b0;
    for (int i = 0; i < 5; i++)
      run_job($sformatf("vec%0d", i), vecs[i].msg, vecs[i].key, vecs[i].res, vecs[i].ops, 0);

    // Table, random multiplier stalls and o_ready held low for 20 cycles.
    stall = 1'b1;
    for (int i = 0; i < 5; i++)
      run_job($sformatf("stall%0d", i), vecs[i].msg, vecs[i].key, vecs[i].res, vecs[i].ops, 20);
    stall = 1'b0;

    // Back-to-back jobs with i_valid held high.
    wait_ready("b2b");
    op_count = 0;
    i_msg = W'(5); i_key = W'(3); i_modulus = W'(N); i_r2 = W'(R2);
    i_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_accept", i_ready, 0);
    i_msg = W'(200); i_key = W'(1);
    cyc = 0;
    while (!o_valid && cyc < TIMEOUT) begin @(negedge clk); cyc++; end
    check("b2b_first_valid", o_valid, 1);
    check("b2b_first_result", o_result, 125);
    check("b2b_first_ops", op_count, 12);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    op_count = 0;
    check("b2b_ready_after_hs", i_ready, 1);
    @(negedge clk);
    check("b2b_second_accept", i_ready, 0);
    i_valid = 1'b0;
    finish_job("b2b_second", 200, 11, 0);

    // Reset in the middle of the exponentiation loop.
    wait_ready("rst_mid");
    op_count = 0;
    i_msg = W'(7); i_key = W'(13); i_modulus = W'(N); i_r2 = W'(R2);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    cyc = 0;
    while (op_count < 5 && cyc < TIMEOUT) begin @(negedge clk); cyc++; end
    check("rst_mid_reached_loop", (op_count >= 5), 1);
    rst = 1'b0;
    #1;
    check("rst_mid_o_valid", o_valid, 0);
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_r_ready", r_ready, 0);
    check("rst_mid_i_ready", i_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_job("post_reset", 7, 13, 176, 13, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
